// File: rtl/harness_pkg.sv
// ----------------------------------------------------------------------------
// harness_pkg
//   Shared types and constants for the UUT run harness.
//   - state_t      : run-controller FSM states (4-bit so the debug word can
//                    show the state in its low nibble)
//   - DBG_SEL_*    : debug-word select codes for dbg_sel_i
//   - ERR_*        : bit positions inside the harness error-flag vector
// ----------------------------------------------------------------------------
package harness_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LAUNCH = 4'd1,
      RUN    = 4'd2,
      CHECK  = 4'd3,
      DONE   = 4'd4
   } state_t;

   localparam logic [1:0] DBG_SEL_STATE   = 2'd0;
   localparam logic [1:0] DBG_SEL_LATENCY = 2'd1;
   localparam logic [1:0] DBG_SEL_MASKS   = 2'd2;
   localparam logic [1:0] DBG_SEL_TIMEOUT = 2'd3;

   localparam int ERR_MISMATCH = 0;
   localparam int ERR_TIMEOUT  = 1;
   localparam int ERR_W        = 2;

endpackage

// File: rtl/uut_channel_capture.sv
// ----------------------------------------------------------------------------
// uut_channel_capture
//   Per-channel completion tracker for one replicated UUT.
//   Detects the 0->1 edge of the channel's end signal while enabled, sets a
//   sticky done flag and latches the channel output at that moment.
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   clear_i  in   synchronous clear of done/edge history/latched output
//   en_i     in   capture window (controller is in RUN)
//   end_i    in   channel end_signal
//   out_i    in   channel output word
//   set_o    out  combinational: done is being set this cycle
//   done_o   out  sticky done flag
//   out_o    out  output latched at the end edge
// ----------------------------------------------------------------------------
module uut_channel_capture #(
   parameter int OUT_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic             end_i,
   input  logic [OUT_W-1:0] out_i,
   output logic             set_o,
   output logic             done_o,
   output logic [OUT_W-1:0] out_o
);

   logic             end_prev_reg;
   logic             done_reg;
   logic [OUT_W-1:0] out_reg;

   // The edge history is cleared to 0 before a run, so an end signal that is
   // already high on the first enabled cycle still registers as an edge.
   assign set_o  = en_i & end_i & ~end_prev_reg & ~done_reg;
   assign done_o = done_reg;
   assign out_o  = out_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         end_prev_reg <= 1'b0;
         done_reg     <= 1'b0;
         out_reg      <= '0;
      end else if (clear_i) begin
         end_prev_reg <= 1'b0;
         done_reg     <= 1'b0;
         out_reg      <= '0;
      end else if (en_i) begin
         end_prev_reg <= end_i;
         if (set_o) begin
            done_reg <= 1'b1;
            out_reg  <= out_i;
         end
      end
   end

endmodule

// File: rtl/uut_harness_ctrl.sv
// ----------------------------------------------------------------------------
// uut_harness_ctrl
//   Run controller between the autotest engine and NUM_CH replicated UUTs.
//   Launches a run on run_rst_i falling, supervises completion of every
//   channel, cross-checks channel outputs against channel 0, measures run
//   latency and aborts hung runs after TMO_CYC cycles.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   run_rst_i    autotest hold/start (1 = hold, 1->0 = start run)
//   run_in_i     autotest test vector (sampled when a run is launched)
//   run_end_o    run finished (held in DONE)
//   run_out_o    channel 0 result (0 after a timeout)
//   run_err_o    channel mismatch or timeout
//   uut_rst_o    shared UUT reset (low only while running)
//   uut_in_o     registered test vector to every channel
//   uut_end_i    per-channel end signals
//   uut_out_i    per-channel outputs, channel k at [k*OUT_W +: OUT_W]
//   dbg_sel_i    debug word select
//   dbg_o        registered debug word
// ----------------------------------------------------------------------------
module uut_harness_ctrl
   import harness_pkg::*;
#(
   parameter int IN_W    = 64,
   parameter int OUT_W   = 128,
   parameter int NUM_CH  = 2,
   parameter int TMO_CYC = 65535,
   parameter int CNT_W   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run_rst_i,
   input  logic [IN_W-1:0]         run_in_i,
   output logic                    run_end_o,
   output logic [OUT_W-1:0]        run_out_o,
   output logic                    run_err_o,
   output logic                    uut_rst_o,
   output logic [IN_W-1:0]         uut_in_o,
   input  logic [NUM_CH-1:0]       uut_end_i,
   input  logic [NUM_CH*OUT_W-1:0] uut_out_i,
   input  logic [1:0]              dbg_sel_i,
   output logic [31:0]             dbg_o
);

   // Timeout limit widened by one bit so it compares cleanly with the counter.
   localparam logic [CNT_W:0] TMO_LIM = (CNT_W+1)'(TMO_CYC);

   state_t state_reg, state_next;

   logic [IN_W-1:0]  uut_in_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] latency_reg;
   logic [NUM_CH-1:0] mismatch_reg;
   logic [ERR_W-1:0] err_flags_reg;
   logic [OUT_W-1:0] run_out_reg;
   logic [31:0]      dbg_reg;
   logic [31:0]      dbg_mux;
   logic [31:0]      lat32;
   logic [7:0]       done8;
   logic [7:0]       mismatch8;

   logic [NUM_CH-1:0] set_w;
   logic [NUM_CH-1:0] done_w;
   logic [NUM_CH-1:0] mismatch_w;
   logic [OUT_W-1:0]  cap_out_w [NUM_CH];

   logic launch_go;
   logic all_done_now;
   logic tmo_hit;

   // ------------------------------------------------------------------
   // Channel capture
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         uut_channel_capture #(
            .OUT_W (OUT_W)
         ) u_cap (
            .clk     (clk),
            .rst     (rst),
            .clear_i (state_reg == LAUNCH),
            .en_i    (state_reg == RUN),
            .end_i   (uut_end_i[gi]),
            .out_i   (uut_out_i[gi*OUT_W +: OUT_W]),
            .set_o   (set_w[gi]),
            .done_o  (done_w[gi]),
            .out_o   (cap_out_w[gi])
         );
      end

      // Channel 0 is the reference, so it can never mismatch itself.
      assign mismatch_w[0] = 1'b0;
      for (gi = 1; gi < NUM_CH; gi++) begin : g_cmp
         assign mismatch_w[gi] = (cap_out_w[gi] != cap_out_w[0]);
      end

      // Debug masks are always 8 bits wide regardless of channel count.
      for (gi = 0; gi < 8; gi++) begin : g_dbg_mask
         if (gi < NUM_CH) begin : g_used
            assign done8[gi]     = done_w[gi];
            assign mismatch8[gi] = mismatch_reg[gi];
         end else begin : g_pad
            assign done8[gi]     = 1'b0;
            assign mismatch8[gi] = 1'b0;
         end
      end

      if (CNT_W >= 32) begin : g_lat_trunc
         assign lat32 = latency_reg[31:0];
      end else begin : g_lat_ext
         assign lat32 = {{(32-CNT_W){1'b0}}, latency_reg};
      end
   endgenerate

   // Done bits including any edge seen this cycle, so simultaneous finishes
   // are counted in the same cycle.
   assign all_done_now = &(done_w | set_w);
   assign cnt_inc      = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
   assign tmo_hit      = ({1'b0, cnt_inc} >= TMO_LIM);
   assign launch_go    = (state_reg == IDLE) && !run_rst_i;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      uut_rst_o  = 1'b1;
      run_end_o  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!run_rst_i) state_next = LAUNCH;
         end
         LAUNCH: begin
            state_next = run_rst_i ? IDLE : RUN;
         end
         RUN: begin
            uut_rst_o = 1'b0;
            // Abort beats a same-cycle completion; completion beats timeout.
            if (run_rst_i)         state_next = IDLE;
            else if (all_done_now) state_next = CHECK;
            else if (tmo_hit)      state_next = DONE;
         end
         CHECK: begin
            state_next = run_rst_i ? IDLE : DONE;
         end
         DONE: begin
            run_end_o = 1'b1;
            if (run_rst_i) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uut_in_reg    <= '0;
         cnt_reg       <= '0;
         latency_reg   <= '0;
         mismatch_reg  <= '0;
         err_flags_reg <= '0;
         run_out_reg   <= '0;
         dbg_reg       <= '0;
      end else begin
         if (launch_go) begin
            uut_in_reg   <= run_in_i;
            cnt_reg      <= '0;
            mismatch_reg <= '0;
         end

         if (state_reg == RUN) begin
            cnt_reg <= cnt_inc;
         end

         if (state_reg == RUN && state_next == DONE) begin
            err_flags_reg[ERR_TIMEOUT] <= 1'b1;
            run_out_reg                <= '0;
         end

         // Results (including latency) are committed only when the run
         // survives CHECK, so an abort leaves the previous latency intact.
         if (state_reg == CHECK && state_next == DONE) begin
            mismatch_reg                <= mismatch_w;
            err_flags_reg[ERR_MISMATCH] <= |mismatch_w;
            run_out_reg                 <= cap_out_w[0];
            latency_reg                 <= cnt_reg;
         end

         if (state_next == IDLE) begin
            err_flags_reg <= '0;
         end

         dbg_reg <= dbg_mux;
      end
   end

   always_comb begin
      dbg_mux = '0;
      case (dbg_sel_i)
         DBG_SEL_STATE:   dbg_mux = {28'b0, state_reg};
         DBG_SEL_LATENCY: dbg_mux = lat32;
         DBG_SEL_MASKS:   dbg_mux = {8'b0, mismatch8, 8'b0, done8};
         DBG_SEL_TIMEOUT: dbg_mux = {31'b0, err_flags_reg[ERR_TIMEOUT]};
         default:         dbg_mux = '0;
      endcase
   end

   assign uut_in_o  = uut_in_reg;
   assign run_out_o = run_out_reg;
   assign run_err_o = |err_flags_reg;
   assign dbg_o     = dbg_reg;

endmodule

// File: tb/tb_uut_harness_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uut_harness_ctrl
//   Drives the autotest side of uut_harness_ctrl and models two UUT channels
//   whose end latency (in RUN cycles, 0 = never) and output are programmable.
// ----------------------------------------------------------------------------
module tb_uut_harness_ctrl;

   localparam int IN_W    = 64;
   localparam int OUT_W   = 128;
   localparam int NUM_CH  = 2;
   localparam int TMO_CYC = 100;
   localparam int CNT_W   = 32;

   logic                    clk;
   logic                    rst;
   logic                    run_rst_i;
   logic [IN_W-1:0]         run_in_i;
   logic                    run_end_o;
   logic [OUT_W-1:0]        run_out_o;
   logic                    run_err_o;
   logic                    uut_rst_o;
   logic [IN_W-1:0]         uut_in_o;
   logic [NUM_CH-1:0]       uut_end_i;
   logic [NUM_CH*OUT_W-1:0] uut_out_i;
   logic [1:0]              dbg_sel_i;
   logic [31:0]             dbg_o;

   uut_harness_ctrl #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .NUM_CH  (NUM_CH),
      .TMO_CYC (TMO_CYC),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run_rst_i (run_rst_i),
      .run_in_i  (run_in_i),
      .run_end_o (run_end_o),
      .run_out_o (run_out_o),
      .run_err_o (run_err_o),
      .uut_rst_o (uut_rst_o),
      .uut_in_o  (uut_in_o),
      .uut_end_i (uut_end_i),
      .uut_out_i (uut_out_i),
      .dbg_sel_i (dbg_sel_i),
      .dbg_o     (dbg_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural UUT channels ----------------
   int           lat_cfg [NUM_CH];
   logic [127:0] val_cfg [NUM_CH];
   int           rcnt;     // completed cycles since UUT reset released
   int           run_cyc;  // RUN cycles of the current run

   always @(posedge clk) begin
      if (uut_rst_o) rcnt <= 0;
      else           rcnt <= rcnt + 1;
   end

   always @(posedge clk) begin
      if (run_rst_i)       run_cyc <= 0;
      else if (!uut_rst_o) run_cyc <= run_cyc + 1;
   end

   // Channel k raises end in its lat_cfg[k]-th cycle out of reset.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         uut_end_i[k] = !uut_rst_o && (lat_cfg[k] != 0) && (rcnt >= lat_cfg[k] - 1);
      end
   end
   assign uut_out_i = {val_cfg[1], val_cfg[0]};

   // ---------------- checking ----------------
   typedef struct {
      logic [63:0]  vec;
      int           lat0;
      int           lat1;
      logic [127:0] v0;
      logic [127:0] v1;
      logic         exp_err;
      logic [127:0] exp_out;
      int           exp_lat;
      int           exp_cyc;
      logic [7:0]   exp_mism;
      logic [7:0]   exp_done;
      logic         exp_tmo;
   } vec_t;

   vec_t tbl [7];
   vec_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   int   last_lat = 0;

   localparam logic [127:0] VA = 128'h0000_1111_2222_3333_4444_5555_6666_ABCD;
   localparam logic [127:0] VB = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_5555_AAAA;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic read_dbg(input logic [1:0] sel, output logic [31:0] val);
      dbg_sel_i = sel;
      @(negedge clk);
      val = dbg_o;
   endtask

   task automatic do_run(input vec_t v, input int idx);
      vec_t        e;
      int          k;
      logic [31:0] d;
      lat_cfg[0] = v.lat0;
      lat_cfg[1] = v.lat1;
      val_cfg[0] = v.v0;
      val_cfg[1] = v.v1;
      run_in_i   = v.vec;
      exp_q.push_back(v);
      @(negedge clk);
      run_rst_i = 1'b0;
      @(negedge clk);
      run_in_i = ~v.vec;   // must be ignored once launched
      k = 0;
      while (!run_end_o && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (!run_end_o) begin
         checks++;
         errors++;
         $display("FAIL run%0d_end_wait: run_end_o=%b required 1 within 400 cycles", idx, run_end_o);
      end else if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL run%0d_scoreboard: queue empty, required one entry", idx);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("run%0d_err", idx), run_err_o, e.exp_err);
         chk($sformatf("run%0d_out", idx), run_out_o, e.exp_out);
         chk($sformatf("run%0d_uut_in", idx), uut_in_o, e.vec);
         chk($sformatf("run%0d_run_cycles", idx), run_cyc, e.exp_cyc);
         chk($sformatf("run%0d_uut_rst_parked", idx), uut_rst_o, 1'b1);
         read_dbg(2'd0, d);
         chk($sformatf("run%0d_dbg_state", idx), d, 32'd4);
         read_dbg(2'd1, d);
         chk($sformatf("run%0d_dbg_latency", idx), d, e.exp_lat);
         read_dbg(2'd2, d);
         chk($sformatf("run%0d_dbg_masks", idx), d, {8'b0, e.exp_mism, 8'b0, e.exp_done});
         read_dbg(2'd3, d);
         chk($sformatf("run%0d_dbg_timeout", idx), d, {31'b0, e.exp_tmo});
         chk($sformatf("run%0d_end_held", idx), run_end_o, 1'b1);
         last_lat = e.exp_lat;
         $display("run %0d: vec=%h err=%b out=%h cycles=%0d", idx, e.vec, run_err_o, run_out_o, run_cyc);
      end
      run_rst_i = 1'b1;
      @(negedge clk);
      chk($sformatf("run%0d_end_drop", idx), run_end_o, 1'b0);
      chk($sformatf("run%0d_err_drop", idx), run_err_o, 1'b0);
   endtask

   // Start a run and reassert run_rst_i at the given RUN cycle count.
   task automatic abort_at(input int cyc, input int lat, input string name);
      int          k;
      int          seen;
      logic [31:0] d;
      lat_cfg[0] = lat;
      lat_cfg[1] = lat;
      val_cfg[0] = VA;
      val_cfg[1] = VA;
      run_in_i   = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      run_rst_i = 1'b0;
      k = 0;
      while (run_cyc != cyc && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_reach"}, run_cyc, cyc);
      run_rst_i = 1'b1;
      @(negedge clk);
      chk({name, "_uut_rst"}, uut_rst_o, 1'b1);
      read_dbg(2'd0, d);
      chk({name, "_state_idle"}, d, 32'd0);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (run_end_o) seen++;
      end
      chk({name, "_no_end"}, seen, 0);
      read_dbg(2'd1, d);
      chk({name, "_latency_kept"}, d, last_lat);
      chk({name, "_err"}, run_err_o, 1'b0);
      $display("%s: aborted at cycle %0d, latency=%0d", name, cyc, d);
   endtask

   initial begin
      logic [31:0] d;
      vec_t        fin;

      //        vec                    l0  l1  v0  v1          err out lat cyc mism   done   tmo
      tbl[0] = '{64'h0123_4567_89AB_CDEF, 40, 40, VA, VA,        1'b0, VA, 40, 40, 8'h00, 8'h03, 1'b0};
      tbl[1] = '{64'hCAFE_F00D_0000_0002, 40, 40, VA, VA ^ 128'h1, 1'b1, VA, 40, 40, 8'h02, 8'h03, 1'b0};
      tbl[2] = '{64'h1234_5678_1234_5678, 30, 55, VB, VB,        1'b0, VB, 55, 55, 8'h00, 8'h03, 1'b0};
      tbl[3] = '{64'h0000_0000_0000_00A5, 20, 0,  VA, VA,        1'b1, '0, 55, 100, 8'h00, 8'h01, 1'b1};
      tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1,  1,  VB, VB,        1'b0, VB, 1,  1,  8'h00, 8'h03, 1'b0};
      tbl[5] = '{64'h5555_AAAA_5555_AAAA, 55, 30, VB, VB ^ {1'b1, 127'b0}, 1'b1, VB, 55, 55, 8'h02, 8'h03, 1'b0};
      tbl[6] = '{64'h0000_0001_0000_0063, 99, 99, VA, VA,        1'b0, VA, 99, 99, 8'h00, 8'h03, 1'b0};

      rst        = 1'b1;
      run_rst_i  = 1'b1;
      run_in_i   = '0;
      dbg_sel_i  = 2'd0;
      lat_cfg[0] = 0;
      lat_cfg[1] = 0;
      val_cfg[0] = '0;
      val_cfg[1] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("reset_uut_rst", uut_rst_o, 1'b1);
      chk("reset_end", run_end_o, 1'b0);
      chk("reset_err", run_err_o, 1'b0);
      chk("reset_out", run_out_o, '0);
      chk("reset_uut_in", uut_in_o, '0);
      read_dbg(2'd1, d);
      chk("reset_latency", d, 32'd0);

      for (int i = 0; i < 7; i++) begin
         do_run(tbl[i], i);
      end

      // Abort 10 cycles into RUN; then abort exactly on the last done.
      abort_at(10, 50, "abort_run");
      abort_at(19, 20, "abort_vs_done");

      // Asynchronous reset between clock edges in the middle of a run.
      lat_cfg[0] = 50;
      lat_cfg[1] = 50;
      run_in_i   = 64'h0BAD_0BAD_0BAD_0BAD;
      @(negedge clk);
      run_rst_i = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("async_pre_running", uut_rst_o, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_uut_rst", uut_rst_o, 1'b1);
      chk("async_end", run_end_o, 1'b0);
      chk("async_err", run_err_o, 1'b0);
      chk("async_out", run_out_o, '0);
      chk("async_uut_in", uut_in_o, '0);
      chk("async_dbg", dbg_o, 32'd0);
      run_rst_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      read_dbg(2'd1, d);
      chk("async_latency_cleared", d, 32'd0);
      last_lat = 0;

      fin = '{64'h1234_5678_1234_5678, 12, 12, VB, VB, 1'b0, VB, 12, 12, 8'h00, 8'h03, 1'b0};
      do_run(fin, 7);

      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
